// File: rtl/regfile_param_if.sv
// Decode/writeback bus of the parametrised register file.
// REGFILE_DEBUG_PORT_EN adds the register-viewer tap (dbg_a/dbg_rd/dbg_busy).
interface regfile_param_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) ();
   logic [ADDR_W-1:0] ra1;
   logic [ADDR_W-1:0] ra2;
   logic [DATA_W-1:0] rd1;
   logic [DATA_W-1:0] rd2;
   logic              we;
   logic [ADDR_W-1:0] wa;
   logic [DATA_W-1:0] wd;
   logic              iss;
   logic [ADDR_W-1:0] iss_a;
   logic              busy1;
   logic              busy2;
   logic [ADDR_W:0]   pend_cnt;
`ifdef REGFILE_DEBUG_PORT_EN
   logic [ADDR_W-1:0] dbg_a;
   logic [DATA_W-1:0] dbg_rd;
   logic              dbg_busy;
`endif

   modport master (
      output ra1, ra2, we, wa, wd, iss, iss_a,
`ifdef REGFILE_DEBUG_PORT_EN
      output dbg_a,
      input  dbg_rd, dbg_busy,
`endif
      input  rd1, rd2, busy1, busy2, pend_cnt
   );

   modport slave (
      input  ra1, ra2, we, wa, wd, iss, iss_a,
`ifdef REGFILE_DEBUG_PORT_EN
      input  dbg_a,
      output dbg_rd, dbg_busy,
`endif
      output rd1, rd2, busy1, busy2, pend_cnt
   );
endinterface

// File: rtl/regfile_param.sv
// Two-read/one-write register file with write-first bypass and a pending-bit scoreboard.
// Optional register-viewer tap enabled by REGFILE_DEBUG_PORT_EN.
module regfile_param #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1
) (
   input logic            clk,
   input logic            rstn,
   regfile_param_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_W;
   localparam bit ZR    = (ZERO_REG != 0);

   logic [DATA_W-1:0] rf [DEPTH];
   logic [DEPTH-1:0]  pend;
   logic [ADDR_W:0]   cnt_q;

   logic wr_ok;
   logic iss_ok;
   logic set_new;
   logic clr_new;

   always_comb begin
      wr_ok   = bus.we  && !(ZR && (bus.wa == '0));
      iss_ok  = bus.iss && !(ZR && (bus.iss_a == '0));
      set_new = iss_ok && !pend[bus.iss_a];
      // A same-address issue keeps the bit set, so that writeback is not a retire.
      clr_new = wr_ok && pend[bus.wa] && !(iss_ok && (bus.iss_a == bus.wa));
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
         pend  <= '0;
         cnt_q <= '0;
      end else begin
         if (wr_ok) begin
            rf[bus.wa]   <= bus.wd;
            pend[bus.wa] <= 1'b0;
         end
         if (iss_ok) pend[bus.iss_a] <= 1'b1;
         cnt_q <= cnt_q + (ADDR_W+1)'(set_new) - (ADDR_W+1)'(clr_new);
      end
   end

   function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] v;
      v = rf[a];
      if (bus.we && (bus.wa == a)) v = bus.wd;
      if (ZR && (a == '0))         v = '0;
      return v;
   endfunction

   function automatic logic busy_port(input logic [ADDR_W-1:0] a);
      return pend[a] && !(bus.we && (bus.wa == a)) && !(ZR && (a == '0));
   endfunction

   assign bus.rd1      = read_port(bus.ra1);
   assign bus.rd2      = read_port(bus.ra2);
   assign bus.busy1    = busy_port(bus.ra1);
   assign bus.busy2    = busy_port(bus.ra2);
   assign bus.pend_cnt = cnt_q;

`ifdef REGFILE_DEBUG_PORT_EN
   assign bus.dbg_rd   = (ZR && (bus.dbg_a == '0)) ? '0 : rf[bus.dbg_a];
   assign bus.dbg_busy = pend[bus.dbg_a];
`endif
endmodule

// File: tb/tb_regfile_param.sv
// Randomised self-checking bench for regfile_param against an array/popcount model.
module tb_regfile_param;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int N  = 1 << AW;

   logic clk;
   logic rstn;
   int   n_tests = 0;
   int   n_fail  = 0;

   logic [DW-1:0] m_rf   [N];
   bit            m_pend [N];

   regfile_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
   regfile_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
      .clk (clk),
      .rstn(rstn),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int m_cnt();
      int c = 0;
      for (int i = 0; i < N; i++) c += int'(m_pend[i]);
      return c;
   endfunction

   function automatic logic [DW-1:0] m_rd(input int a);
      if (a == 0) return '0;
      if (bus.we && int'(bus.wa) == a) return bus.wd;
      return m_rf[a];
   endfunction

   function automatic logic m_busy(input int a);
      if (a == 0) return 1'b0;
      if (bus.we && int'(bus.wa) == a) return 1'b0;
      return m_pend[a];
   endfunction

   task automatic model_clear();
      for (int i = 0; i < N; i++) begin
         m_rf[i]   = '0;
         m_pend[i] = 1'b0;
      end
   endtask

   // One rising edge; the model applies what the DUT sampled, then outputs settle.
   task automatic step();
      @(posedge clk);
      if (rstn) begin
         if (bus.we && bus.wa != 0) m_rf[bus.wa] = bus.wd;
         if (bus.we) m_pend[bus.wa] = 1'b0;
         if (bus.iss && bus.iss_a != 0) m_pend[bus.iss_a] = 1'b1;
      end
      #1;
   endtask

   task automatic idle();
      bus.we = 0; bus.wa = '0; bus.wd = '0; bus.iss = 0; bus.iss_a = '0;
   endtask

   task automatic do_reset();
      idle();
      rstn = 1'b0;
      #3;
      model_clear();
      step();
      rstn = 1'b1;
      step();
   endtask

   task automatic test_reset();
      for (int i = 0; i < N; i++) begin
         bus.we = 1; bus.wa = AW'(i); bus.wd = 32'hFFFF_FFFF;
         bus.iss = 1; bus.iss_a = AW'(i);
         step();
      end
      idle();
      bus.ra1 = 5; bus.ra2 = 31;
      #1;
      n_tests++;
      if (bus.rd1 !== 32'hFFFF_FFFF) begin
         n_fail++; $display("FAIL pre_reset_rd1 got %h want ffffffff", bus.rd1);
      end
      #2 rstn = 1'b0;
      model_clear();
      #1;
      n_tests++;
      if (bus.rd1 !== 32'h0 || bus.rd2 !== 32'h0) begin
         n_fail++; $display("FAIL reset_rd got %h/%h want 0/0", bus.rd1, bus.rd2);
      end
      n_tests++;
      if (bus.pend_cnt !== 6'd0 || bus.busy1 !== 1'b0 || bus.busy2 !== 1'b0) begin
         n_fail++; $display("FAIL reset_pend cnt %0d busy %b%b want 0 00", bus.pend_cnt, bus.busy1, bus.busy2);
      end
      bus.we = 1; bus.wa = 31; bus.wd = 32'h1234_5678; bus.iss = 1; bus.iss_a = 31;
      step();
      idle();
      #1;
      n_tests++;
      if (bus.rd2 !== 32'h0 || bus.pend_cnt !== 6'd0) begin
         n_fail++; $display("FAIL reset_hold rd2 %h cnt %0d want 0 0", bus.rd2, bus.pend_cnt);
      end
      #2 rstn = 1'b1;
      step();
   endtask

   task automatic test_zero_reg();
      int c0;
      c0 = m_cnt();
      bus.we = 1; bus.wa = 0; bus.wd = 32'h1234; bus.iss = 1; bus.iss_a = 0;
      bus.ra1 = 0;
      #1;
      n_tests++;
      if (bus.rd1 !== 32'h0 || bus.busy1 !== 1'b0) begin
         n_fail++; $display("FAIL zero_same_cycle rd1 %h busy1 %b want 0 0", bus.rd1, bus.busy1);
      end
      step();
      idle();
      #1;
      n_tests++;
      if (bus.rd1 !== 32'h0 || bus.busy1 !== 1'b0 || int'(bus.pend_cnt) != c0) begin
         n_fail++; $display("FAIL zero_after rd1 %h busy1 %b cnt %0d want 0 0 %0d", bus.rd1, bus.busy1, bus.pend_cnt, c0);
      end
   endtask

   task automatic test_bypass();
      bus.we = 1; bus.wa = 5; bus.wd = 32'hAAAA_5555;
      step();
      bus.ra1 = 5; bus.we = 1; bus.wa = 5; bus.wd = 32'hDEAD_BEEF;
      #1;
      n_tests++;
      if (bus.rd1 !== 32'hDEAD_BEEF) begin
         n_fail++; $display("FAIL bypass_rd1 got %h want deadbeef", bus.rd1);
      end
      step();
      idle();
      #1;
      n_tests++;
      if (bus.rd1 !== 32'hDEAD_BEEF) begin
         n_fail++; $display("FAIL bypass_stored got %h want deadbeef", bus.rd1);
      end
   endtask

   task automatic test_scoreboard();
      do_reset();
      bus.ra2 = 7; bus.ra1 = 3;
      bus.iss = 1; bus.iss_a = 7;
      step();
      idle();
      #1;
      n_tests++;
      if (bus.busy2 !== 1'b1 || bus.pend_cnt !== 6'd1) begin
         n_fail++; $display("FAIL sb_issue busy2 %b cnt %0d want 1 1", bus.busy2, bus.pend_cnt);
      end
      bus.we = 1; bus.wa = 7; bus.wd = 32'h0000_0777; bus.iss = 1; bus.iss_a = 3;
      #1;
      n_tests++;
      if (bus.busy2 !== 1'b0 || bus.rd2 !== 32'h0000_0777) begin
         n_fail++; $display("FAIL sb_wb_cycle busy2 %b rd2 %h want 0 00000777", bus.busy2, bus.rd2);
      end
      step();
      idle();
      #1;
      n_tests++;
      if (bus.busy2 !== 1'b0 || bus.busy1 !== 1'b1 || bus.pend_cnt !== 6'd1) begin
         n_fail++; $display("FAIL sb_after busy2 %b busy1 %b cnt %0d want 0 1 1", bus.busy2, bus.busy1, bus.pend_cnt);
      end
   endtask

   task automatic test_same_addr();
      logic [DW-1:0] d;
      d = $urandom;
      bus.ra1 = 9;
      bus.iss = 1; bus.iss_a = 9; bus.we = 1; bus.wa = 9; bus.wd = d;
      #1;
      n_tests++;
      if (bus.rd1 !== d) begin
         n_fail++; $display("FAIL same_addr_rd got %h want %h", bus.rd1, d);
      end
      step();
      idle();
      #1;
      n_tests++;
      if (bus.busy1 !== 1'b1 || bus.pend_cnt !== 6'd2 || bus.rd1 !== d) begin
         n_fail++; $display("FAIL same_addr_after busy1 %b cnt %0d rd1 %h want 1 2 %h", bus.busy1, bus.pend_cnt, bus.rd1, d);
      end
   endtask

   task automatic test_full_count();
      do_reset();
      for (int i = 1; i < N; i++) begin
         bus.iss = 1; bus.iss_a = AW'(i);
         step();
      end
      idle();
      #1;
      n_tests++;
      if (bus.pend_cnt !== 6'd31) begin
         n_fail++; $display("FAIL full_count got %0d want 31", bus.pend_cnt);
      end
      for (int i = 1; i < N; i++) begin
         bus.we = 1; bus.wa = AW'(i); bus.wd = $urandom;
         step();
      end
      idle();
      #1;
      n_tests++;
      if (bus.pend_cnt !== 6'd0) begin
         n_fail++; $display("FAIL drain_count got %0d want 0", bus.pend_cnt);
      end
      bus.we = 1; bus.wa = 4; bus.wd = 32'h4;
      step();
      idle();
      bus.ra1 = 4;
      #1;
      n_tests++;
      if (bus.pend_cnt !== 6'd0 || bus.busy1 !== 1'b0) begin
         n_fail++; $display("FAIL extra_retire cnt %0d busy1 %b want 0 0", bus.pend_cnt, bus.busy1);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int cyc = 0; cyc < 600; cyc++) begin
         bus.ra1   = AW'($urandom_range(0, N-1));
         bus.ra2   = ($urandom_range(0, 3) == 0) ? bus.ra1 : AW'($urandom_range(0, N-1));
         bus.we    = ($urandom_range(0, 1) == 1);
         bus.wa    = ($urandom_range(0, 2) == 0) ? bus.ra1 : AW'($urandom_range(0, N-1));
         bus.wd    = $urandom;
         bus.iss   = ($urandom_range(0, 1) == 1);
         bus.iss_a = ($urandom_range(0, 3) == 0) ? bus.wa : AW'($urandom_range(0, N-1));
         #1;
         n_tests++;
         if (bus.rd1 !== m_rd(int'(bus.ra1)) || bus.rd2 !== m_rd(int'(bus.ra2))) begin
            n_fail++;
            $display("FAIL rand_rd cyc %0d got %h/%h want %h/%h", cyc, bus.rd1, bus.rd2,
                     m_rd(int'(bus.ra1)), m_rd(int'(bus.ra2)));
         end
         n_tests++;
         if (bus.busy1 !== m_busy(int'(bus.ra1)) || bus.busy2 !== m_busy(int'(bus.ra2))) begin
            n_fail++;
            $display("FAIL rand_busy cyc %0d got %b%b want %b%b", cyc, bus.busy1, bus.busy2,
                     m_busy(int'(bus.ra1)), m_busy(int'(bus.ra2)));
         end
         step();
         n_tests++;
         if (int'(bus.pend_cnt) != m_cnt()) begin
            n_fail++; $display("FAIL rand_cnt cyc %0d got %0d want %0d", cyc, bus.pend_cnt, m_cnt());
         end
      end
      idle();
   endtask

   initial begin
      rstn = 1'b1;
      idle();
      bus.ra1 = '0; bus.ra2 = '0;
`ifdef REGFILE_DEBUG_PORT_EN
      bus.dbg_a = '0;
`endif
      do_reset();
      test_reset();
      test_zero_reg();
      test_bypass();
      test_scoreboard();
      test_same_addr();
      test_full_count();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised successor of the core's register file.
- Width and depth are configurable; register 0 can optionally be hard-wired to zero.
- Write-to-read bypass on both read ports.
- Asynchronous clear of the whole array.
- Per-register pending (scoreboard) bits, set at issue and cleared at writeback, so the pipeline controller can detect RAW hazards.
- Sits between the decode stage (reads, issue) and the writeback stage (writes).

Parameters:
- DATA_W, 32, register data width in bits.
- ADDR_W, 5, address width; depth is 2**ADDR_W.
- ZERO_REG, 1, when 1 register 0 always reads 0, ignores writes and never becomes pending.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rstn  input  1  asynchronous active-low reset.
- ra1  input  ADDR_W  read address, port 1.
- ra2  input  ADDR_W  read address, port 2.
- rd1  output  DATA_W  read data, port 1 (combinational).
- rd2  output  DATA_W  read data, port 2 (combinational).
- we  input  1  writeback enable.
- wa  input  ADDR_W  writeback address.
- wd  input  DATA_W  writeback data.
- iss  input  1  issue strobe; marks register iss_a pending.
- iss_a  input  ADDR_W  destination register of the issued instruction.
- busy1  output  1  register ra1 is pending (combinational).
- busy2  output  1  register ra2 is pending (combinational).
- pend_cnt  output  ADDR_W+1  number of registers currently pending (registered).

Behaviour:
- Reset (rstn=0, asynchronous, no clock needed):
  - all array entries = 0, all pending bits = 0, pend_cnt = 0.
  - rd1/rd2 therefore read 0; busy1/busy2 = 0.
  - Reset asserted mid-operation discards any write or issue in that cycle.
  - Release is synchronous to the next rising edge; no state changes while rstn=0.
- Write: on a rising edge with we=1, rf[wa] <= wd. When ZERO_REG=1 and wa=0 the write is dropped.
- Read (combinational, zero latency):
  - rdN = 0 when ZERO_REG=1 and raN=0.
  - else rdN = wd when we=1 and wa=raN (write-first bypass).
  - else rdN = rf[raN].
  - ra1 = ra2 is legal; both ports return the same value.
- Pending bits, updated on each rising edge:
  - Set: iss=1 sets pend[iss_a], unless ZERO_REG=1 and iss_a=0.
  - Clear: we=1 clears pend[wa].
  - iss=1 and we=1 on the same address in one cycle: set wins, so the bit ends at 1 (the newer producer is outstanding).
  - iss on an already-pending register: bit stays 1, no count change.
  - we on a non-pending register: data is written, bit stays 0, no count change.
- Busy outputs:
  - busyN = pend[raN] AND NOT (we=1 AND wa=raN); a same-cycle writeback satisfies the hazard via the bypass.
  - busyN = 0 for address 0 when ZERO_REG=1.
- pend_cnt:
  - Registered; next value = current + (bit newly set ? 1 : 0) − (bit newly cleared ? 1 : 0).
  - Both events on different addresses in one cycle: net 0.
  - Range 0 .. 2**ADDR_W (full count representable); no wrap.
- No other timing: all outputs except pend_cnt are combinational from inputs and state.

Optional Feature:
- Macro: REGFILE_DEBUG_PORT_EN.
- Defined:
  - adds input dbg_a [ADDR_W] and outputs dbg_rd [DATA_W] and dbg_busy [1].
  - dbg_rd = rf[dbg_a] raw array contents (no bypass; zero rule still applies).
  - dbg_busy = pend[dbg_a] raw.
  - Intended for the on-board register viewer.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset with all registers written to 0xFFFFFFFF, then rstn=0 between clock edges -> rd1=rd2=0 immediately; pend_cnt=0.
- ZERO_REG=1: we=1, wa=0, wd=0x1234, iss=1, iss_a=0 -> ra1=0 gives rd1=0; busy1=0; pend_cnt unchanged.
- Bypass: write 0xAAAA5555 to x5; next cycle ra1=5 with we=1, wa=5, wd=0xDEADBEEF -> rd1=0xDEADBEEF same cycle; after the edge rf[5]=0xDEADBEEF.
- Scoreboard, with ra2=7 held:
  - iss x7 -> busy2=1, pend_cnt=1.
  - we x7 with iss x3 in the same cycle -> busy2=0 during that cycle; afterwards pend[7]=0, pend[3]=1, pend_cnt=1.
- Same-address conflict: iss=1, iss_a=9 together with we=1, wa=9 -> pend[9]=1, pend_cnt +1; rd of x9 = wd during that cycle.
- Full count, ADDR_W=5, ZERO_REG=1: issue x1..x31 -> pend_cnt=31; retire all -> pend_cnt=0, with no underflow on an extra retire of x4.
